// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one RS-232 byte transmitter among N_REQ byte sources.
// Grants one byte per frame, waits for TxDone (or timeout), then holds an inter-frame gap.
module uart_tx_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned GAP_CYC     = 32,
  parameter int unsigned TIMEOUT_CYC = 2**20
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_REQ-1:0]   Req,
  input  logic [8*N_REQ-1:0] ReqData,
  output logic [N_REQ-1:0]   Ack,
  output logic               TxEn,
  output logic [7:0]         TxData,
  input  logic               TxDone,
  output logic               Busy,
  output logic [2:0]         GrantId,
  output logic               TimeoutErr,
  input  logic               ClrErr
);

  localparam logic [23:0] TO_LAST  = 24'(TIMEOUT_CYC - 1);
  localparam logic [23:0] GAP_LAST = 24'(GAP_CYC - 1);
  localparam logic [2:0]  GID_RST  = 3'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] cnt, cnt_nxt;
  logic        done_s1, done_s2, done_s3, done_rise;
  logic [7:0]  req_ext;
  logic [63:0] data_ext;
  logic        pick_valid;
  logic [2:0]  pick_id, scan_id;
  logic        timeout_hit, gap_end;
  logic        tx_en_nxt, err_set;
  logic [7:0]  ack_nxt, data_nxt;
  logic [2:0]  gid_nxt;

  // Widened copies let a 3-bit id index requests for any N_REQ up to 8.
  assign req_ext  = 8'(Req);
  assign data_ext = 64'(ReqData);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_s3 <= 1'b0;
    end else begin
      done_s1 <= TxDone;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
    end
  end

  assign done_rise   = done_s2 & ~done_s3;
  assign timeout_hit = (cnt == TO_LAST);
  assign gap_end     = (cnt == GAP_LAST);

  // Search upward from the slot after the last grant, wrapping; first hit wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = GrantId;
    scan_id    = GrantId;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      scan_id = 3'((32'(GrantId) + i) % N_REQ);
      if (!pick_valid && req_ext[scan_id]) begin
        pick_valid = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_valid) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_rise || timeout_hit) state_nxt = GAP;
      GAP:       if (gap_end) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_en_nxt = 1'b0;
    ack_nxt   = '0;
    err_set   = 1'b0;
    cnt_nxt   = cnt;
    data_nxt  = TxData;
    gid_nxt   = GrantId;
    Busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_valid) begin
          data_nxt = data_ext[{pick_id, 3'b000} +: 8];
          gid_nxt  = pick_id;
          cnt_nxt  = '0;
        end
      end
      LAUNCH: begin
        tx_en_nxt = 1'b1;
        cnt_nxt   = '0;
      end
      WAIT_DONE: begin
        if (done_rise) begin
          ack_nxt[GrantId] = 1'b1;
          cnt_nxt          = '0;
        end else if (timeout_hit) begin
          ack_nxt[GrantId] = 1'b1;
          err_set          = 1'b1;
          cnt_nxt          = '0;
        end else begin
          tx_en_nxt = 1'b1;
          cnt_nxt   = cnt + 24'd1;
        end
      end
      GAP: begin
        cnt_nxt = gap_end ? '0 : cnt + 24'd1;
      end
      default: ;
    endcase
  end

  // Outputs are registered so the transmitter sees glitch-free TxEn/TxData.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      TxEn       <= 1'b0;
      Ack        <= '0;
      TxData     <= '0;
      GrantId    <= GID_RST;
      TimeoutErr <= 1'b0;
      cnt        <= '0;
    end else begin
      TxEn    <= tx_en_nxt;
      Ack     <= ack_nxt[N_REQ-1:0];
      TxData  <= data_nxt;
      GrantId <= gid_nxt;
      cnt     <= cnt_nxt;
      if (err_set)     TimeoutErr <= 1'b1;
      else if (ClrErr) TimeoutErr <= 1'b0;
    end
  end

endmodule
